// File: rtl/huffman_decoder.sv
// huffman_decoder
//   Serial Huffman decoder. A 6-entry code table (code word + contiguous LSB
//   mask per entry) is loaded on a code_valid pulse. Bits then arrive MSB-first,
//   one per bit_valid/bit_ready handshake. When the accumulated bits equal an
//   entry's code at that entry's length, the symbol SYM_BASE+i-1 is presented
//   on sym_valid/sym_data. If CODE_W bits accumulate without a match, err
//   pulses for one cycle and decoding restarts with the next bit.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   Valid never waits for ready. Once sym_valid is high, sym_valid and
//   sym_data hold until sym_ready is seen.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   code_valid         one-cycle table load strobe (wins over bit/symbol traffic)
//   HC1..HC6, M1..M6   code words and masks (M=0 marks an unused entry)
//   bit_in/bit_valid/bit_ready   serial bit input stream
//   sym_data/sym_valid/sym_ready decoded symbol output stream
//   err                one-cycle pulse when no code matched in CODE_W bits
//   state_dbg          current FSM state (0 = EMPTY, 1 = RUN)
//   dec_count          symbols delivered, saturating (HUFF_DEC_STATS_EN only)
//
// Build option: define HUFF_DEC_STATS_EN to add the dec_count output.
module huffman_decoder #(
  parameter int          CODE_W   = 8,
  parameter logic [7:0]  SYM_BASE = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [7:0]        sym_data,
  output logic              err,
  output logic              state_dbg
`ifdef HUFF_DEC_STATS_EN
  ,
  output logic [15:0]       dec_count
`endif
);

  localparam int LW = $clog2(CODE_W + 1);

  typedef enum logic {EMPTY = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [CODE_W-1:0] hc_in [6];
  logic [CODE_W-1:0] m_in  [6];
  logic [CODE_W-1:0] hc_q  [6];
  logic [CODE_W-1:0] m_q   [6];
  logic [LW-1:0]     l_q   [6];

  logic [CODE_W-1:0] shift, next_shift;
  logic [LW-1:0]     len, nlen;
  logic              accept, hit, full;
  logic [2:0]        hit_idx;

  assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign m_in  = '{M1, M2, M3, M4, M5, M6};

  function automatic logic [LW-1:0] popcount(input logic [CODE_W-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int k = 0; k < CODE_W; k++) c = c + LW'(v[k]);
    return c;
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  // FSM: next state and bit_ready. A table load cycle never takes a bit, so
  // bit_ready is suppressed while code_valid is high.
  always_comb begin
    state_nxt = state;
    bit_ready = 1'b0;
    if (code_valid) state_nxt = RUN;
    if (state == RUN && !code_valid) bit_ready = !sym_valid || sym_ready;
  end

  assign state_dbg = state;
  assign accept    = bit_valid && bit_ready;

  // Match search on the shift contents including the incoming bit. The loop
  // runs from the top entry down so the lowest matching index is kept.
  always_comb begin
    next_shift = {shift[CODE_W-2:0], bit_in};
    nlen       = len + LW'(1);
    full       = (nlen == LW'(CODE_W));
    hit        = 1'b0;
    hit_idx    = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (l_q[i] != '0 && l_q[i] == nlen && (next_shift & m_q[i]) == hc_q[i]) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
        l_q[i]  <= '0;
      end
      shift     <= '0;
      len       <= '0;
      sym_data  <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else if (code_valid) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i] <= hc_in[i];
        m_q[i]  <= m_in[i];
        l_q[i]  <= popcount(m_in[i]);
      end
      shift     <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (sym_valid && sym_ready) sym_valid <= 1'b0;
      if (accept) begin
        if (hit) begin
          // A new match overrides the drop above: back-to-back symbols.
          sym_valid <= 1'b1;
          sym_data  <= SYM_BASE + {5'd0, hit_idx};
          shift     <= '0;
          len       <= '0;
        end else if (full) begin
          err   <= 1'b1;
          shift <= '0;
          len   <= '0;
        end else begin
          shift <= next_shift;
          len   <= nlen;
        end
      end
    end
  end

`ifdef HUFF_DEC_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  dec_count <= '0;
    else if (code_valid)                         dec_count <= '0;
    else if (sym_valid && sym_ready && dec_count != 16'hFFFF)
                                                 dec_count <= dec_count + 16'd1;
  end
`endif

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Receiving end of the Huffman coding path. Loads the 6-entry code table (HC1..HC6, M1..M6) when the encoder pulses code_valid.
- Accepts a serial bitstream, one bit per handshake, and emits the decoded gray-level symbol (1..6) on a valid/ready output.
- Flags any bit sequence that matches no code within CODE_W bits.

Parameters:
- CODE_W, 8: width of each HCi/Mi entry; maximum code length.
- SYM_BASE, 1: symbol value emitted for table entry 1 (entry i emits SYM_BASE+i-1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when reset=0).
- code_valid  input  1  one-cycle pulse; table entries are valid this cycle.
- HC1..HC6  input  CODE_W each  code words, LSB-aligned.
- M1..M6  input  CODE_W each  masks, contiguous ones from the LSB; the number of ones is the code length; M=0 means entry unused.
- bit_in  input  1  serial code bit; first-sent bit is the code MSB.
- bit_valid  input  1  bit_in valid.
- bit_ready  output  1  decoder accepts a bit this cycle.
- sym_valid  output  1  sym_data holds a decoded symbol.
- sym_ready  input  1  downstream consumes the symbol.
- sym_data  output  8  decoded symbol.
- err  output  1  one-cycle pulse: no code matched after CODE_W bits.

Behaviour:
- Reset (async, reset=0): state=EMPTY; table, shift, len, sym_data, sym_valid, err and bit_ready all 0.
- Table load: on code_valid=1 in any state:
  - latch HCi, Mi and Li=popcount(Mi);
  - clear shift and len; drop any pending symbol (sym_valid=0);
  - go to RUN next cycle.
  - code_valid has priority over a simultaneous bit or symbol handshake; that bit is not consumed.
- States:
  - EMPTY: bit_ready=0 until the first table load.
  - RUN: bit_ready=1 when !sym_valid || sym_ready, i.e. one symbol of buffering with full-throughput pass-through.
- Bit accept (bit_valid && bit_ready): next_shift={shift[CODE_W-2:0],bit_in}, nlen=len+1.
- Match rule: entry i matches when Li!=0, Li==nlen and (next_shift & Mi)==HCi. Lowest index wins if several match; a prefix-free table never produces more than one.
- On match:
  - next cycle sym_valid=1, sym_data=SYM_BASE+i-1;
  - shift and len are cleared.
  - Latency: symbol is valid 1 cycle after its last bit is accepted.
- No match, nlen<CODE_W: store next_shift and nlen.
- No match, nlen==CODE_W: pulse err next cycle, clear shift and len, no symbol emitted. Decoding resumes at the next bit.
- Output hold: sym_data and sym_valid stay stable while sym_valid && !sym_ready. sym_valid drops after sym_ready unless a new match lands in the same cycle (back-to-back).
- Reset mid-symbol: all partial state and the table are lost; the block returns to EMPTY.

Optional Feature:
- Macro: HUFF_DEC_STATS_EN.
- Defined: adds output dec_count[15:0], the number of symbols emitted (counted on sym_valid && sym_ready).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by code_valid.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Table HC1..6=0,2,6,14,30,31 with M=1,3,7,15,31,31 (codes 0,10,110,1110,11110,11111); stream bits 0,1,0,1,1,1,1,1 with sym_ready=1 -> sym_data 1,2,6; each symbol valid one cycle after its last bit.
- Same table, sym_ready=0 after the first symbol, keep bit_valid=1 -> bit_ready=0; sym_data=1 held stable; no bits lost once sym_ready rises.
- Table with M6=0, stream 1,1,1,1,1 then bits 0,0,0 -> no match at length 5; err pulses once after the 8th bit; the next 0 decodes as symbol 1.
- Before any code_valid, bit_valid=1 -> bit_ready=0, no sym_valid; after code_valid, the first bit 0 yields symbol 1.
- code_valid asserted after the partial bits 1,1 -> partial code discarded; the following stream 1,0 decodes as symbol 2, not 4.
- reset=0 pulse mid-symbol -> all outputs 0 asynchronously; bit_ready stays 0 until the next code_valid.
